cruise_sequencer: RTL and testbench

- Sequencing controller for the cruise-control ALU (modes: 00 pass, 01 compare, 10 +5, 11 −5; out_speed and L/EQ/G registered one clock after mode is applied).
- Holds the desired-speed register and feeds it to the ALU.
- Turns driver buttons (set/resume/accel/coast/cancel/brake) into ALU mode sequences.
- Converts ALU compare flags into throttle_up/throttle_down commands for the actuator.

---
 rtl/cc_pkg.sv | 20 ++
 rtl/cc_edge_detect.sv | 21 ++
 rtl/cruise_sequencer.sv | 133 +++++++++++++
 tb/tb_cruise_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// Shared definitions for the cruise-control sequencer: FSM states, ALU mode codes
// and the fixed speed step applied by accel/coast.
package cc_pkg;

    typedef enum logic [2:0] {
        OFF         = 3'd0,
        STANDBY     = 3'd1,
        CRUISE      = 3'd2,
        ADJ_ISSUE   = 3'd3,
        ADJ_CAPTURE = 3'd4
    } cc_state_e;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_CMP  = 2'b01;
    localparam logic [1:0] MODE_ADD  = 2'b10;
    localparam logic [1:0] MODE_SUB  = 2'b11;

    localparam logic [7:0] STEP = 8'd5;

endpackage

// File: rtl/cc_edge_detect.sv
// Single-cycle pulse on a rising edge of a level input; history clears on reset.
module cc_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic level_i,
    output logic pulse_o
);

    logic prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~prev_q;

endmodule

// File: rtl/cruise_sequencer.sv
// Cruise-control sequencer: turns driver buttons into ALU mode sequences, owns the
// desired-speed register and converts ALU compare flags into throttle requests.
module cruise_sequencer
    import cc_pkg::*;
#(
    parameter logic [7:0] MIN_SPEED = 8'd40,
    parameter logic [7:0] MAX_SPEED = 8'd200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cruise_on,
    input  logic       set_btn,
    input  logic       resume_btn,
    input  logic       accel_btn,
    input  logic       coast_btn,
    input  logic       cancel_btn,
    input  logic       brake,
    input  logic [7:0] c_speed,
    input  logic [7:0] alu_out_speed,
    input  logic       alu_l,
    input  logic       alu_eq,
    input  logic       alu_g,
    output logic [1:0] alu_mode,
    output logic [7:0] d_speed,
    output logic       target_valid,
    output logic       active,
    output logic       throttle_up,
    output logic       throttle_down
);

    cc_state_e  state_q, state_d;
    logic [7:0] d_speed_q, d_speed_d;
    logic       target_valid_q, target_valid_d;
    logic       cmp_valid_q, cmp_valid_d;
    logic       dir_up_q, dir_up_d;

    logic set_pulse, resume_pulse, accel_pulse, coast_pulse;
    logic stop_req, c_in_range, can_up, can_down, relatch, may_throttle;

    cc_edge_detect u_set_edge    (.clock(clock), .reset(reset), .level_i(set_btn),    .pulse_o(set_pulse));
    cc_edge_detect u_resume_edge (.clock(clock), .reset(reset), .level_i(resume_btn), .pulse_o(resume_pulse));
    cc_edge_detect u_accel_edge  (.clock(clock), .reset(reset), .level_i(accel_btn),  .pulse_o(accel_pulse));
    cc_edge_detect u_coast_edge  (.clock(clock), .reset(reset), .level_i(coast_btn),  .pulse_o(coast_pulse));

    assign stop_req   = brake | cancel_btn;
    assign c_in_range = (c_speed >= MIN_SPEED) && (c_speed <= MAX_SPEED);
    assign can_up     = d_speed_q <= (MAX_SPEED - STEP);
    assign can_down   = d_speed_q >= (MIN_SPEED + STEP);

    // An event that is not allowed to act (e.g. set out of range) falls through to the next one.
    always_comb begin
        state_d        = state_q;
        d_speed_d      = d_speed_q;
        target_valid_d = target_valid_q;
        dir_up_d       = dir_up_q;
        relatch        = 1'b0;
        if (!cruise_on) begin
            state_d        = OFF;
            target_valid_d = 1'b0;
        end else begin
            case (state_q)
                OFF: state_d = STANDBY;
                STANDBY: begin
                    if (stop_req) begin
                        state_d = STANDBY;
                    end else if (set_pulse && c_in_range) begin
                        d_speed_d      = c_speed;
                        target_valid_d = 1'b1;
                        state_d        = CRUISE;
                    end else if (resume_pulse && target_valid_q) begin
                        state_d = CRUISE;
                    end
                end
                CRUISE: begin
                    if (stop_req) begin
                        state_d = STANDBY;
                    end else if (set_pulse && c_in_range) begin
                        d_speed_d = c_speed;
                        relatch   = 1'b1;
                    end else if (accel_pulse && can_up) begin
                        dir_up_d = 1'b1;
                        state_d  = ADJ_ISSUE;
                    end else if (coast_pulse && can_down) begin
                        dir_up_d = 1'b0;
                        state_d  = ADJ_ISSUE;
                    end
                end
                ADJ_ISSUE:   state_d = stop_req ? STANDBY : ADJ_CAPTURE;
                ADJ_CAPTURE: begin
                    d_speed_d = alu_out_speed;
                    state_d   = stop_req ? STANDBY : CRUISE;
                end
                default: state_d = OFF;
            endcase
        end
    end

    // Flags lag the compare mode by a clock, so trust them only after a full steady CRUISE cycle.
    assign cmp_valid_d = (state_q == CRUISE) && (state_d == CRUISE) && !relatch;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= OFF;
            d_speed_q      <= 8'd0;
            target_valid_q <= 1'b0;
            cmp_valid_q    <= 1'b0;
            dir_up_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            d_speed_q      <= d_speed_d;
            target_valid_q <= target_valid_d;
            cmp_valid_q    <= cmp_valid_d;
            dir_up_q       <= dir_up_d;
        end
    end

    always_comb begin
        case (state_q)
            CRUISE, ADJ_CAPTURE: alu_mode = MODE_CMP;
            ADJ_ISSUE:           alu_mode = dir_up_q ? MODE_ADD : MODE_SUB;
            default:             alu_mode = MODE_PASS;
        endcase
    end

    assign may_throttle  = (state_q == CRUISE) && cmp_valid_q && !stop_req && !alu_eq;
    assign throttle_up   = may_throttle && alu_l;
    assign throttle_down = may_throttle && alu_g && !alu_l;

    assign d_speed      = d_speed_q;
    assign target_valid = target_valid_q;
    assign active       = (state_q == CRUISE) || (state_q == ADJ_ISSUE) || (state_q == ADJ_CAPTURE);

endmodule

// File: tb/tb_cruise_sequencer.sv
// Scoreboard bench for cruise_sequencer: a behavioural model predicts each cycle's
// outputs, a monitor compares them against the DUT at the falling edge.
module tb_cruise_sequencer;

    localparam logic [7:0] MIN_S = 8'd40;
    localparam logic [7:0] MAX_S = 8'd200;
    localparam bit [5:0] SET = 6'b100000, RES = 6'b010000, ACC = 6'b001000;
    localparam bit [5:0] COA = 6'b000100, CAN = 6'b000010, BRK = 6'b000001, NONE = 6'b000000;

    logic       clock = 1'b0;
    logic       reset, cruise_on, set_btn, resume_btn, accel_btn, coast_btn, cancel_btn, brake;
    logic [7:0] c_speed;
    logic [7:0] alu_out_speed = 8'd0;
    logic       alu_l = 1'b0, alu_eq = 1'b0, alu_g = 1'b0;
    logic [1:0] alu_mode;
    logic [7:0] d_speed;
    logic       target_valid, active, throttle_up, throttle_down;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] d;
        logic       tv;
        logic       act;
        logic       up;
        logic       dn;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Behavioural model: 0 off, 1 standby, 2 cruise, 3 adjust-issue, 4 adjust-capture.
    int         mSt = 0;
    logic [7:0] mD = 0, mPend = 0, mPrevC = 0;
    bit         mTv = 0, mSteady = 0;
    bit         pSet = 0, pRes = 0, pAcc = 0, pCoa = 0;

    always #5 clock = ~clock;

    cruise_sequencer #(.MIN_SPEED(MIN_S), .MAX_SPEED(MAX_S)) dut (
        .clock(clock), .reset(reset), .cruise_on(cruise_on),
        .set_btn(set_btn), .resume_btn(resume_btn), .accel_btn(accel_btn),
        .coast_btn(coast_btn), .cancel_btn(cancel_btn), .brake(brake),
        .c_speed(c_speed), .alu_out_speed(alu_out_speed),
        .alu_l(alu_l), .alu_eq(alu_eq), .alu_g(alu_g),
        .alu_mode(alu_mode), .d_speed(d_speed), .target_valid(target_valid),
        .active(active), .throttle_up(throttle_up), .throttle_down(throttle_down)
    );

    // Environment ALU: registered result, flags only refresh in compare mode and have no reset.
    always @(posedge clock) begin
        case (alu_mode)
            2'b10:   alu_out_speed <= d_speed + 8'd5;
            2'b11:   alu_out_speed <= d_speed - 8'd5;
            default: alu_out_speed <= d_speed;
        endcase
        if (alu_mode == 2'b01) begin
            alu_l  <= c_speed < d_speed;
            alu_eq <= c_speed == d_speed;
            alu_g  <= c_speed > d_speed;
        end
    end

    task automatic advanceModel();
        bit setE, resE, accE, coaE, stop, inRange, relatched;
        int nSt;
        setE = set_btn && !pSet;
        resE = resume_btn && !pRes;
        accE = accel_btn && !pAcc;
        coaE = coast_btn && !pCoa;
        stop = brake || cancel_btn;
        inRange = (c_speed >= MIN_S) && (c_speed <= MAX_S);
        relatched = 0;
        if (reset) begin
            mSt = 0; mD = 0; mTv = 0; mSteady = 0; mPend = 0;
            pSet = 0; pRes = 0; pAcc = 0; pCoa = 0;
            return;
        end
        nSt = mSt;
        if (!cruise_on) begin
            nSt = 0;
            mTv = 0;
        end else if (mSt == 0) begin
            nSt = 1;
        end else if (mSt == 1) begin
            if (!stop && setE && inRange) begin
                mD = c_speed; mTv = 1; nSt = 2;
            end else if (!stop && resE && mTv) begin
                nSt = 2;
            end
        end else if (mSt == 2) begin
            if (stop) nSt = 1;
            else if (setE && inRange) begin
                mD = c_speed; relatched = 1;
            end else if (accE && int'(mD) + 5 <= int'(MAX_S)) begin
                mPend = mD + 8'd5; nSt = 3;
            end else if (coaE && int'(mD) - 5 >= int'(MIN_S)) begin
                mPend = mD - 8'd5; nSt = 3;
            end
        end else if (mSt == 3) begin
            nSt = stop ? 1 : 4;
        end else begin
            mD = mPend;
            nSt = stop ? 1 : 2;
        end
        mSteady = (mSt == 2) && (nSt == 2) && !relatched;
        mPrevC = c_speed;
        mSt = nSt;
        pSet = set_btn; pRes = resume_btn; pAcc = accel_btn; pCoa = coast_btn;
    endtask

    function automatic exp_t predict();
        exp_t e;
        bit ok;
        e.mode = (mSt == 2 || mSt == 4) ? 2'b01 : (mSt == 3) ? ((mPend > mD) ? 2'b10 : 2'b11) : 2'b00;
        e.d    = mD;
        e.tv   = mTv;
        e.act  = mSt >= 2;
        ok     = (mSt == 2) && mSteady && !brake && !cancel_btn;
        e.up   = ok && (mPrevC < mD);
        e.dn   = ok && (mPrevC > mD);
        return e;
    endfunction

    task automatic applyStimulus(input bit on, input bit [5:0] b, input logic [7:0] c, input bit rst);
        @(posedge clock);
        advanceModel();
        #1;
        reset = rst; cruise_on = on; c_speed = c;
        {set_btn, resume_btn, accel_btn, coast_btn, cancel_btn, brake} = b;
        sbq.push_back(predict());
    endtask

    task automatic hold(input int n, input logic [7:0] c);
        for (int i = 0; i < n; i++) applyStimulus(1, NONE, c, 0);
    endtask

    task automatic checkOutput(input exp_t e);
        exp_t a;
        a = '{alu_mode, d_speed, target_valid, active, throttle_up, throttle_down};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("[TB] FAIL cycle_outputs t=%0t got mode=%b d=%0d tv=%b act=%b up=%b dn=%b expected mode=%b d=%0d tv=%b act=%b up=%b dn=%b",
                     $time, a.mode, a.d, a.tv, a.act, a.up, a.dn, e.mode, e.d, e.tv, e.act, e.up, e.dn);
        end
    endtask

    always @(negedge clock) begin
        if (sbq.size() > 0) checkOutput(sbq.pop_front());
    end

    initial begin
        bit [5:0] lvl;
        reset = 1; cruise_on = 0; c_speed = 8'd100;
        {set_btn, resume_btn, accel_btn, coast_btn, cancel_btn, brake} = NONE;
        applyStimulus(0, NONE, 100, 1);
        applyStimulus(0, NONE, 100, 1);
        hold(2, 100);
        applyStimulus(1, SET, 100, 0);
        hold(3, 90); hold(3, 110); hold(3, 100);
        applyStimulus(1, ACC, 100, 0); hold(5, 100);
        applyStimulus(1, COA, 100, 0); hold(5, 100);
        for (int i = 0; i < 10; i++) applyStimulus(1, ACC, 100, 0);
        hold(3, 100);
        applyStimulus(1, COA, 100, 0); hold(4, 100);
        applyStimulus(1, SET, 198, 0); hold(2, 198);
        applyStimulus(1, ACC, 198, 0); hold(4, 198);
        applyStimulus(1, SET, 43, 0); hold(2, 43);
        applyStimulus(1, COA, 43, 0); hold(4, 43);
        applyStimulus(1, SET, 100, 0); hold(3, 100);
        applyStimulus(1, ACC, 100, 0);
        applyStimulus(1, BRK, 100, 0);
        hold(2, 100);
        applyStimulus(1, RES, 100, 0); hold(3, 95);
        applyStimulus(0, NONE, 100, 0);
        hold(2, 100);
        applyStimulus(1, RES, 100, 0); hold(2, 100);
        applyStimulus(1, SET, 100, 0); hold(2, 100);
        applyStimulus(1, ACC, 100, 0); hold(1, 100);
        applyStimulus(1, NONE, 100, 1);
        hold(3, 100);

        lvl = NONE;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 2; k < 6; k++) if ($urandom_range(0, 3) == 0) lvl[k] = ~lvl[k];
            lvl[1] = $urandom_range(0, 19) == 0;
            lvl[0] = $urandom_range(0, 19) == 0;
            applyStimulus($urandom_range(0, 59) != 0, lvl, 8'($urandom_range(30, 210)),
                          $urandom_range(0, 499) == 0);
        end

        @(negedge clock);
        @(negedge clock);
        if (sbq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
